decode_seq: RTL and testbench

//  Sequencer for the ByteDecode_l core (decode). Walks a byte-packed object in word memory and streams
//  64-bit words into decode, one polynomial at a time, with the correct l for each polynomial.

---
 rtl/kyber_pkg.sv | 52 +++++
 rtl/dseq_fifo2.sv | 42 ++++
 rtl/decode_seq.sv | 139 +++++++++++++
 tb/tb_decode_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants: object mode encodings, l tables and the per-polynomial
// word/poly count helpers used by the decode sequencer.
package kyber_pkg;

  typedef enum logic [1:0] {
    MODE_SK  = 2'd0,
    MODE_PK  = 2'd1,
    MODE_CT  = 2'd2,
    MODE_MSG = 2'd3
  } mode_e;

  localparam logic [3:0] L_12 = 4'd12;
  localparam logic [3:0] L_1  = 4'd1;

  localparam int unsigned WORDS_PER_L = 4;

  // Ranks outside 2..4 fall back to 2.
  function automatic logic [2:0] k_norm(input logic [2:0] k);
    return ((k >= 3'd2) && (k <= 3'd4)) ? k : 3'd2;
  endfunction

  function automatic logic [3:0] du_of(input logic [2:0] k);
    return (k == 3'd4) ? 4'd11 : 4'd10;
  endfunction

  function automatic logic [3:0] dv_of(input logic [2:0] k);
    return (k == 3'd4) ? 4'd5 : 4'd4;
  endfunction

  function automatic logic [2:0] npoly_of(input mode_e mode, input logic [2:0] k);
    logic [2:0] n;
    case (mode)
      MODE_CT:  n = k + 3'd1;
      MODE_MSG: n = 3'd1;
      default:  n = k;
    endcase
    return n;
  endfunction

  // Ciphertext: the first k polys are u (du bits), the last is v (dv bits).
  function automatic logic [3:0] l_of(input mode_e mode, input logic [2:0] k,
                                      input logic [2:0] idx);
    logic [3:0] l;
    case (mode)
      MODE_CT:  l = (idx < k) ? du_of(k) : dv_of(k);
      MODE_MSG: l = L_1;
      default:  l = L_12;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dseq_fifo2.sv
// Two-entry 64-bit FIFO buffering RAM read data ahead of the decode core.
module dseq_fifo2 (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_push,
  input  logic [63:0] i_wdata,
  input  logic        i_pop,
  output logic [63:0] o_rdata,
  output logic [1:0]  o_count,
  output logic        o_empty
);

  logic [63:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;
  logic        push_ok, pop_ok;

  assign pop_ok  = i_pop && (count_q != 2'd0);
  assign push_ok = i_push && ((count_q != 2'd2) || pop_ok);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_empty = (count_q == 2'd0);

endmodule

// File: rtl/decode_seq.sv
// Sequencer that walks a byte-packed object in word RAM and streams 64-bit words
// into the ByteDecode core one polynomial at a time, with the right l per poly.
module decode_seq #(
  parameter int unsigned AW          = 10,
  parameter int unsigned WORDS_PER_L = kyber_pkg::WORDS_PER_L
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic [1:0]    i_mode,
  input  logic [2:0]    i_k,
  input  logic [AW-1:0] i_base,
  output logic          o_ren,
  output logic [AW-1:0] o_raddr,
  input  logic [63:0]   i_rdata,
  output logic [63:0]   o_dec_ibytes,
  output logic          o_dec_valid,
  input  logic          i_dec_ready,
  output logic [3:0]    o_dec_l,
  input  logic          i_dec_done,
  output logic [2:0]    o_poly_idx,
  output logic          o_busy,
  output logic          o_done
);
  import kyber_pkg::*;

  localparam int unsigned CW = $clog2(WORDS_PER_L * 15 + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [2:0]    k_q, k_d;
  logic [2:0]    poly_q, poly_d;
  logic [3:0]    l_q, l_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          inflight_q;

  logic [CW-1:0] words;
  logic [1:0]    fifo_count;
  logic          fifo_empty;
  logic          pop, ren;
  logic [2:0]    slots_used;

  assign words = CW'(WORDS_PER_L * 32'(l_q));
  assign pop   = !fifo_empty && i_dec_ready;

  // Counting the same-cycle pop frees its slot early, which is what lets the
  // stream sustain one word per cycle without ever pushing into a full FIFO.
  assign slots_used = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign ren = (state_q == StLoad) && (rd_cnt_q != words) && (slots_used < 3'd2);

  dseq_fifo2 u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (inflight_q),
    .i_wdata (i_rdata),
    .i_pop   (pop),
    .o_rdata (o_dec_ibytes),
    .o_count (fifo_count),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    k_d      = k_q;
    poly_d   = poly_q;
    l_d      = l_q;
    addr_d   = addr_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d  = StLoad;
          mode_d   = mode_e'(i_mode);
          k_d      = k_norm(i_k);
          poly_d   = 3'd0;
          l_d      = l_of(mode_e'(i_mode), k_norm(i_k), 3'd0);
          addr_d   = i_base;
          rd_cnt_d = '0;
        end
      end
      StLoad: begin
        if (ren) begin
          addr_d   = addr_q + 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_d == words) state_d = StWait;
        end
      end
      StWait: begin
        if (i_dec_done) begin
          if (poly_q == npoly_of(mode_q, k_q) - 3'd1) begin
            state_d = StDone;
          end else begin
            state_d  = StLoad;
            poly_d   = poly_q + 3'd1;
            l_d      = l_of(mode_q, k_q, poly_q + 3'd1);
            rd_cnt_d = '0;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      mode_q     <= MODE_SK;
      k_q        <= 3'd0;
      poly_q     <= 3'd0;
      l_q        <= 4'd0;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      poly_q     <= poly_d;
      l_q        <= l_d;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      inflight_q <= ren;
    end
  end

  assign o_ren       = ren;
  assign o_raddr     = addr_q;
  assign o_dec_valid = !fifo_empty;
  assign o_dec_l     = l_q;
  assign o_poly_idx  = poly_q;
  assign o_busy      = (state_q == StLoad) || (state_q == StWait);
  assign o_done      = (state_q == StDone);

endmodule

// File: tb/tb_decode_seq.sv
// Self-checking bench for decode_seq: RAM model, decode-core model and a scoreboard
// of expected words (data, l, poly index) built from the object layout.
module tb_decode_seq;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [2:0]    k = 3'd2;
  logic [AW-1:0] base = '0;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [63:0]   rdata = '0;
  logic [63:0]   dec_ibytes;
  logic          dec_valid;
  logic          dec_ready = 1'b0;
  logic [3:0]    dec_l;
  logic          dec_done = 1'b0;
  logic [2:0]    poly_idx;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [1024];

  typedef struct {
    logic [63:0] data;
    logic [3:0]  l;
    logic [2:0]  poly;
    bit          last;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (ren) rdata <= mem[raddr];

  decode_seq #(.AW(AW), .WORDS_PER_L(4)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_mode       (mode),
    .i_k          (k),
    .i_base       (base),
    .o_ren        (ren),
    .o_raddr      (raddr),
    .i_rdata      (rdata),
    .o_dec_ibytes (dec_ibytes),
    .o_dec_valid  (dec_valid),
    .i_dec_ready  (dec_ready),
    .o_dec_l      (dec_l),
    .i_dec_done   (dec_done),
    .o_poly_idx   (poly_idx),
    .o_busy       (busy),
    .o_done       (done)
  );

  function automatic int exp_l(input int m, input int kk, input int p);
    if (m == 0 || m == 1) return 12;
    if (m == 3) return 1;
    if (p < kk) return (kk == 4) ? 11 : 10;
    return (kk == 4) ? 5 : 4;
  endfunction

  // Runs one whole object. ready_pct sets decode readiness; at inject_iter a
  // spurious start (with a different mode) and a spurious done are driven.
  task automatic run_object(input int m, input int kin, input logic [AW-1:0] b,
                            input int ready_pct, input int inject_iter, input string name);
    int            kk, np, lp, total, nreads, first_valid;
    logic [AW-1:0] a, exp_addr;
    bit            done_pending, seen_done, prev_stall;
    logic [63:0]   prev_data;
    exp_t          e;
    kk = (kin >= 2 && kin <= 4) ? kin : 2;
    np = (m == 2) ? kk + 1 : ((m == 3) ? 1 : kk);
    sb.delete();
    a = b;
    for (int p = 0; p < np; p++) begin
      lp = exp_l(m, kk, p);
      for (int i = 0; i < 4 * lp; i++) begin
        sb.push_back('{data: mem[a], l: 4'(lp), poly: 3'(p), last: (i == 4 * lp - 1)});
        a = a + 1'b1;
      end
    end
    total = sb.size();
    nreads = 0;
    first_valid = -1;
    exp_addr = b;
    done_pending = 0;
    seen_done = 0;
    prev_stall = 0;
    prev_data = '0;

    @(negedge clk);
    start = 1'b1; mode = 2'(m); k = 3'(kin); base = b; dec_ready = 1'b0;
    for (int it = 0; it < 3000 && !seen_done; it++) begin
      @(negedge clk);
      start = (it == inject_iter);
      if (it == inject_iter) begin
        mode = 2'd3;
        base = '0;
      end
      dec_done = done_pending || (it == inject_iter);
      done_pending = 0;
      dec_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (it == 0) begin
        checks++;
        if (ren !== 1'b1 || raddr !== b || busy !== 1'b1 || dec_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s first_cycle: ren=%b raddr=%h busy=%b valid=%b, want 1 %h 1 0",
                   name, ren, raddr, busy, dec_valid, b);
        end
      end
      if (dec_valid === 1'b1 && first_valid < 0) begin
        first_valid = it;
        checks++;
        if (it != 2) begin
          errors++;
          $display("FAIL %s first_valid_latency: got cycle %0d, want 2", name, it);
        end
      end
      if (prev_stall) begin
        checks++;
        if (dec_valid !== 1'b1 || dec_ibytes !== prev_data) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b data=%h, want 1 %h",
                   name, dec_valid, dec_ibytes, prev_data);
        end
      end
      if (ren === 1'b1) begin
        nreads++;
        checks++;
        if (raddr !== exp_addr) begin
          errors++;
          $display("FAIL %s raddr: got %h, want %h", name, raddr, exp_addr);
        end
        exp_addr = exp_addr + 1'b1;
      end
      if (dec_valid === 1'b1 && dec_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat: got data=%h, want no beat", name, dec_ibytes);
        end else begin
          e = sb.pop_front();
          if (dec_ibytes !== e.data || dec_l !== e.l || poly_idx !== e.poly) begin
            errors++;
            $display("FAIL %s beat: got data=%h l=%0d poly=%0d, want data=%h l=%0d poly=%0d",
                     name, dec_ibytes, dec_l, poly_idx, e.data, e.l, e.poly);
          end
          if (e.last) done_pending = 1;
        end
      end
      prev_stall = (dec_valid === 1'b1) && !dec_ready;
      prev_data = dec_ibytes;
      if (done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (busy !== 1'b0 || sb.size() != 0 || nreads != total) begin
          errors++;
          $display("FAIL %s done_state: busy=%b left=%0d reads=%0d, want 0 0 %0d",
                   name, busy, sb.size(), nreads, total);
        end
      end
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: o_done never seen, want o_done pulse", name);
    end
    @(negedge clk);
    start = 1'b0; dec_done = 1'b0; dec_ready = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ren !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b ren=%b, want 0 0 0", name, done, busy, ren);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({ren, dec_valid, busy, done, raddr, dec_l, poly_idx} !== '0) begin
      errors++;
      $display("FAIL reset_init: ren=%b valid=%b busy=%b done=%b raddr=%h l=%0d poly=%0d, want 0",
               ren, dec_valid, busy, done, raddr, dec_l, poly_idx);
    end
    @(negedge clk);
    rstn = 1'b1; start = 1'b1; mode = 2'd0; k = 3'd2; base = 10'h100; dec_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || dec_valid !== 1'b1 || dec_l !== 4'd12) begin
      errors++;
      $display("FAIL reset_midload_pre: busy=%b valid=%b l=%0d, want 1 1 12",
               busy, dec_valid, dec_l);
    end
    rstn = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({ren, dec_valid, busy, done, raddr, dec_l, poly_idx} !== '0) begin
      errors++;
      $display("FAIL reset_midload: ren=%b valid=%b busy=%b done=%b raddr=%h l=%0d poly=%0d, want 0",
               ren, dec_valid, busy, done, raddr, dec_l, poly_idx);
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ren !== 1'b0 || dec_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet: ren=%b valid=%b busy=%b, want 0 0 0", ren, dec_valid, busy);
      end
    end
  endtask

  task automatic test_msg;
    run_object(3, 2, 10'h020, 100, -1, "msg");
  endtask

  task automatic test_ct_k3;
    run_object(2, 3, 10'h3c0, 100, -1, "ct_k3_wrap");
  endtask

  task automatic test_ct_k4;
    run_object(2, 4, 10'h100, 100, -1, "ct_k4");
  endtask

  task automatic test_sk_random_ready;
    run_object(0, 2, 10'h200, 50, -1, "sk_rand");
  endtask

  task automatic test_busy_ignore;
    run_object(1, 3, 10'h050, 100, 5, "pk_busy");
  endtask

  task automatic test_invalid_k;
    run_object(0, 7, 10'h300, 100, -1, "sk_badk");
  endtask

  task automatic test_back_to_back;
    run_object(3, 4, 10'h3fe, 70, -1, "msg_b2b");
    run_object(2, 2, 10'h010, 100, -1, "ct_k2");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    test_reset;
    test_msg;
    test_ct_k3;
    test_ct_k4;
    test_sk_random_ready;
    test_busy_ignore;
    test_invalid_k;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
